// File: rtl/mac_accumulator.sv
// Dot-product accumulator behind a fixed-latency multiplier, with a 2-entry output FIFO.
// Optional clamping of the sum is enabled by defining MAC_ACCUMULATOR_SATURATE_EN.
module mac_accumulator #(
    parameter int WIDTH       = 16,
    parameter int PIPE_STAGES = 10,
    parameter int ACC_WIDTH   = 40,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 op_valid,
    input  logic                 op_last,
    input  logic [2*WIDTH-1:0]   product,
    output logic                 sum_valid,
    input  logic                 sum_ready,
    output logic [ACC_WIDTH-1:0] sum_data,
    output logic [CNT_WIDTH-1:0] sum_count,
    output logic                 sum_sat,
    output logic                 overflow
);

    generate
        if (PIPE_STAGES < 1 || ACC_WIDTH < 2*WIDTH) begin : gen_param_check
            $error("mac_accumulator: need PIPE_STAGES >= 1 and ACC_WIDTH >= 2*WIDTH");
        end
    endgenerate

    logic [PIPE_STAGES-1:0] validPipe_q;
    logic [PIPE_STAGES-1:0] lastPipe_q;
    logic                   tValid;
    logic                   tLast;

    logic [ACC_WIDTH-1:0]   acc_q;
    logic [ACC_WIDTH-1:0]   acc_d;
    logic [ACC_WIDTH-1:0]   accInc;
    logic [CNT_WIDTH-1:0]   cnt_q;
    logic [CNT_WIDTH-1:0]   cnt_d;
    logic [CNT_WIDTH-1:0]   cntInc;

    logic                   pend_q;
    logic [ACC_WIDTH-1:0]   pendData_q;
    logic [CNT_WIDTH-1:0]   pendCnt_q;

    logic [ACC_WIDTH-1:0]   dataMem_q [2];
    logic [CNT_WIDTH-1:0]   cntMem_q  [2];
    logic                   wrPtr_q;
    logic                   rdPtr_q;
    logic [1:0]             occ_q;
    logic [1:0]             occ_d;
    logic                   pop;
    logic                   accept;
    logic                   overflow_q;

`ifdef MAC_ACCUMULATOR_SATURATE_EN
    logic                   sat_q;
    logic                   sat_d;
    logic                   satInc;
    logic                   pendSat_q;
    logic [ACC_WIDTH:0]     sumWide;
    logic                   satMem_q [2];
`endif

    // Valid/last ride alongside the multiplier so the taps line up with its product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            validPipe_q <= '0;
            lastPipe_q  <= '0;
        end else begin
            validPipe_q <= (validPipe_q << 1) | PIPE_STAGES'(op_valid);
            lastPipe_q  <= (lastPipe_q << 1) | PIPE_STAGES'(op_valid & op_last);
        end
    end

    assign tValid = validPipe_q[PIPE_STAGES-1];
    assign tLast  = lastPipe_q[PIPE_STAGES-1];

    always_comb begin
`ifdef MAC_ACCUMULATOR_SATURATE_EN
        sumWide = {1'b0, acc_q} + (ACC_WIDTH+1)'(product);
        accInc  = sumWide[ACC_WIDTH] ? '1 : sumWide[ACC_WIDTH-1:0];
        satInc  = sat_q | sumWide[ACC_WIDTH];
        sat_d   = sat_q;
`else
        accInc  = acc_q + ACC_WIDTH'(product);
`endif
        cntInc  = cnt_q + CNT_WIDTH'(1);
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (tValid) begin
            if (tLast) begin
                acc_d = '0;
                cnt_d = '0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                sat_d = 1'b0;
`endif
            end else begin
                acc_d = accInc;
                cnt_d = cntInc;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                sat_d = satInc;
`endif
            end
        end
    end

    // A completed sum is staged one cycle before entering the FIFO, keeping the adder off the buffer path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pendData_q <= '0;
            pendCnt_q  <= '0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
            sat_q      <= 1'b0;
            pendSat_q  <= 1'b0;
`endif
        end else begin
            acc_q  <= acc_d;
            cnt_q  <= cnt_d;
            pend_q <= tValid & tLast;
            if (tValid & tLast) begin
                pendData_q <= accInc;
                pendCnt_q  <= cntInc;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                pendSat_q  <= satInc;
`endif
            end
`ifdef MAC_ACCUMULATOR_SATURATE_EN
            sat_q <= sat_d;
`endif
        end
    end

    assign pop    = sum_valid & sum_ready;
    assign accept = pend_q & ((occ_q != 2'd2) | pop);
    assign occ_d  = occ_q + 2'(accept) - 2'(pop);

    // When full with a simultaneous pop, the write lands in the slot being vacated.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                dataMem_q[i] <= '0;
                cntMem_q[i]  <= '0;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                satMem_q[i]  <= 1'b0;
`endif
            end
            wrPtr_q    <= 1'b0;
            rdPtr_q    <= 1'b0;
            occ_q      <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                dataMem_q[wrPtr_q] <= pendData_q;
                cntMem_q[wrPtr_q]  <= pendCnt_q;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
                satMem_q[wrPtr_q]  <= pendSat_q;
`endif
                wrPtr_q <= ~wrPtr_q;
            end
            if (pop) begin
                rdPtr_q <= ~rdPtr_q;
            end
            occ_q <= occ_d;
            if (pend_q & ~accept) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign sum_valid = (occ_q != 2'd0);
    assign sum_data  = dataMem_q[rdPtr_q];
    assign sum_count = cntMem_q[rdPtr_q];
    assign overflow  = overflow_q;
`ifdef MAC_ACCUMULATOR_SATURATE_EN
    assign sum_sat   = satMem_q[rdPtr_q];
`else
    assign sum_sat   = 1'b0;
`endif

endmodule
